// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle RV32I ALU-instruction decode/sequencing stage
// feeding the register file. IDLE -> DECODE -> EXEC -> WB, one write per
// legal instruction, never to x0.
// Optional feature macro: INSTR_SEQ_RETIRE_CNT_EN adds the `retired` counter.

module instr_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [AW-1:0]   ra1,
  output logic [AW-1:0]   ra2,
  output logic [2:0]      alu_op,
  output logic            alu_src,
  output logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  output logic            we3,
  output logic            illegal
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  ,
  output logic [XLEN-1:0] retired
`endif
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned IMM_W  = 12;
  localparam int unsigned FLD_W  = 5;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_Z  = 7'b0000000;
  localparam logic [6:0] F7_S  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5
  } alu_op_t;

  typedef struct packed {
    logic            legal;
    logic [OP_W-1:0] op;
    logic            src;
  } dec_t;

  // Maps funct3 to the shared ALU operation; ok=0 for unsupported funct3.
  function automatic logic [OP_W:0] f3_op(input logic [2:0] f3);
    logic [OP_W:0] r;
    r = '0;
    case (f3)
      3'b000:  r = {1'b1, OP_ADD};
      3'b111:  r = {1'b1, OP_AND};
      3'b110:  r = {1'b1, OP_OR};
      3'b100:  r = {1'b1, OP_XOR};
      3'b010:  r = {1'b1, OP_SLT};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Full legality and ALU-control decode of one instruction word.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t          d;
    logic [OP_W:0] f;
    d = '0;
    f = f3_op(w[14:12]);
    case (w[6:0])
      OPC_R: begin
        d.src = 1'b0;
        if (w[31:25] == F7_Z) begin
          d.legal = f[OP_W];
          d.op    = f[OP_W-1:0];
        end else if ((w[31:25] == F7_S) && (w[14:12] == 3'b000)) begin
          d.legal = 1'b1;
          d.op    = OP_SUB;
        end
      end
      OPC_I: begin
        d.src   = 1'b1;
        d.legal = f[OP_W];
        d.op    = f[OP_W-1:0];
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [FLD_W-1:0]  rd_q, rd_d;
  logic [AW-1:0]     ra1_q, ra1_d;
  logic [AW-1:0]     ra2_q, ra2_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              alu_src_q, alu_src_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [AW-1:0]     wa3_q, wa3_d;
  logic [XLEN-1:0]   wd3_q, wd3_d;
  logic              we3_q, we3_d;
  logic              illegal_q, illegal_d;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  logic [XLEN-1:0]   retired_q, retired_d;
`endif

  dec_t              dec;
  logic [IMM_W-1:0]  imm_fld;

  // Decode of the word on the bus, latched at the handshake so the
  // decoded controls are already registered during DECODE.
  always_comb begin
    dec     = decode(instr[31:0]);
    imm_fld = instr[31:20];
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    ra1_d     = ra1_q;
    ra2_d     = ra2_q;
    alu_op_d  = alu_op_q;
    alu_src_d = alu_src_q;
    imm_d     = imm_q;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    we3_d     = 1'b0;
    illegal_d = 1'b0;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    retired_d = retired_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d   = S_DECODE;
          rd_d      = instr[11:7];
          ra1_d     = AW'(instr[19:15]);
          ra2_d     = AW'(instr[24:20]);
          imm_d     = {{(XLEN-IMM_W){imm_fld[IMM_W-1]}}, imm_fld};
          illegal_d = ~dec.legal;
          if (dec.legal) begin
            alu_op_d  = dec.op;
            alu_src_d = dec.src;
          end
        end
      end
      S_DECODE: begin
        state_d = illegal_q ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        wd3_d   = alu_result;
        wa3_d   = AW'(rd_q);
        we3_d   = (rd_q != '0);
      end
      S_WB: begin
        state_d = S_IDLE;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        retired_d = retired_q + XLEN'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      ra1_q     <= '0;
      ra2_q     <= '0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      imm_q     <= '0;
      wa3_q     <= '0;
      wd3_q     <= '0;
      we3_q     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      retired_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      ra1_q     <= ra1_d;
      ra2_q     <= ra2_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      imm_q     <= imm_d;
      wa3_q     <= wa3_d;
      wd3_q     <= wd3_d;
      we3_q     <= we3_d;
      illegal_q <= illegal_d;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      retired_q <= retired_d;
`endif
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign ra1         = ra1_q;
  assign ra2         = ra2_q;
  assign alu_op      = alu_op_q;
  assign alu_src     = alu_src_q;
  assign imm         = imm_q;
  assign wa3         = wa3_q;
  assign wd3         = wd3_q;
  assign we3         = we3_q;
  assign illegal     = illegal_q;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  assign retired     = retired_q;
`endif

endmodule
